// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter sharing one byte-level I2C write master
// Ports:
//   i2c_clk, reset          clock and synchronous active-high reset
//   req/req_addr/req_data   per-requester request level, 7-bit address, data byte (flat slices)
//   gnt/done/err            one-hot grant, one-cycle completion pulse, error flag valid with done
//   m_start/m_addr/m_data   launch strobe and latched transfer to the master
//   m_busy/m_done/m_nack    master status, completion pulse, nack flag valid with m_done
//   busy/state_out          non-idle indication and raw state encoding
module i2c_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i2c_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_nack,
  output logic                 busy,
  output logic [2:0]           state_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_GAP = 3'd3;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               flag_q, flag_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic               start_q, start_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;

  logic [IW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;
  logic [6:0]         win_addr;
  logic [7:0]         win_data;
  logic               arb, launch, wd_hit, gap_end, retry_ok, rty, fin;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w, j;
    w = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(p) + k) % NUM_REQ);
      if (r[j]) w = j;
    end
    return w;
  endfunction

  always_ff @(posedge i2c_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      flag_q  <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      flag_q  <= flag_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = |req ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = m_busy ? S_ISSUE : S_WAIT;
      S_WAIT:  state_d = (m_done || wd_hit) ? S_GAP : S_WAIT;
      S_GAP:   state_d = gap_end ? (flag_q ? S_ISSUE : S_IDLE) : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    win      = rr_pick(req, ptr_q);
    win_oh   = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win == IW'(i));
      if (win == IW'(i)) begin
        win_addr = req_addr[7*i +: 7];
        win_data = req_data[8*i +: 8];
      end
    end
    arb      = (state_q == S_IDLE) && |req;
    launch   = (state_q == S_ISSUE) && !m_busy;
    wd_hit   = wd_q == WD_LIMIT;
    gap_end  = (state_q == S_GAP) && (gap_q == GAP_LAST);
    retry_ok = m_nack && (retry_q < MAX_R);
    // m_done takes priority over a watchdog expiry in the same cycle.
    rty      = (state_q == S_WAIT) && m_done && retry_ok;
    fin      = (state_q == S_WAIT) && (m_done ? !retry_ok : wd_hit);
    idx_d    = arb ? win : idx_q;
    gnt_d    = arb ? win_oh : (fin ? '0 : gnt_q);
    addr_d   = arb ? win_addr : addr_q;
    data_d   = arb ? win_data : data_q;
    retry_d  = arb ? '0 : (rty ? retry_q + 1'b1 : retry_q);
    flag_d   = rty ? 1'b1 : (gap_end ? 1'b0 : flag_q);
    wd_d     = launch ? '0 : ((state_q == S_WAIT) && !wd_hit ? wd_q + 1'b1 : wd_q);
    gap_d    = (state_q == S_GAP) && !gap_end ? gap_q + 1'b1 : '0;
    start_d  = launch;
    done_d   = fin ? gnt_q : '0;
    err_d    = fin && (!m_done || m_nack) ? gnt_q : '0;
    ptr_d    = fin ? (idx_q == LAST_IDX ? '0 : idx_q + 1'b1) : ptr_q;
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign m_start   = start_q;
  assign m_addr    = addr_q;
  assign m_data    = data_q;
  assign busy      = state_q != S_IDLE;
  assign state_out = state_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
  logic        i2c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt, done, err;
  logic        m_start, m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0, busy;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic [2:0]  state_out;
  int          total = 0, bad = 0, n;

  i2c_txn_arbiter dut (
    .i2c_clk(i2c_clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .busy(busy), .state_out(state_out)
  );

  always #5 i2c_clk = ~i2c_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick;
    @(negedge i2c_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_start"}, 32'(m_start), 0);
    chk({tag, "_addr"}, 32'(m_addr), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_state"}, 32'(state_out), 0);
  endtask

  task automatic wait_start(input string tag);
    n = 0;
    while (m_start !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
    chk(tag, 32'(m_start), 1);
  endtask

  task automatic wait_idle(input string tag);
    n = 0;
    while (state_out !== 3'd0 && n < 400) begin
      tick;
      n++;
    end
    chk(tag, 32'(state_out), 0);
  endtask

  task automatic master_done(input logic nack);
    m_done = 1'b1;
    m_nack = nack;
    tick;
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7] = 7'(7'h10 + i);
      req_data[8*i +: 8] = 8'(8'hA0 + i);
    end
    req_addr[14 +: 7] = 7'h69;
    req_data[16 +: 8] = 8'hAA;
    tick;
    tick;
    chk_zero("rst");
    reset = 1'b0;

    // single requester, master busy for one ISSUE cycle
    req = 4'b0100;
    m_busy = 1'b1;
    tick;
    chk("s_gnt", 32'(gnt), 32'h4);
    chk("s_addr", 32'(m_addr), 32'h69);
    chk("s_data", 32'(m_data), 32'hAA);
    chk("s_state_issue", 32'(state_out), 1);
    chk("s_busy", 32'(busy), 1);
    tick;
    chk("s_hold_start", 32'(m_start), 0);
    chk("s_hold_state", 32'(state_out), 1);
    m_busy = 1'b0;
    tick;
    chk("s_start", 32'(m_start), 1);
    chk("s_state_wait", 32'(state_out), 2);
    tick;
    chk("s_start_pulse", 32'(m_start), 0);
    master_done(1'b0);
    req = 4'b0000;
    chk("s_done", 32'(done), 32'h4);
    chk("s_err", 32'(err), 0);
    chk("s_gnt_clr", 32'(gnt), 0);
    chk("s_state_gap", 32'(state_out), 3);
    for (int i = 0; i < 7; i++) tick;
    chk("s_done_pulse", 32'(done), 0);
    chk("s_gap_busy", 32'(busy), 1);
    tick;
    chk("s_idle_busy", 32'(busy), 0);
    chk("s_idle_state", 32'(state_out), 0);

    // fairness with all requesters held from reset
    req = 4'b1111;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      wait_start("f_start");
      chk("f_gnt", 32'(gnt), 32'(1 << (i % 4)));
      chk("f_addr", 32'(m_addr), (i % 4) == 2 ? 32'h69 : 32'(8'h10 + (i % 4)));
      master_done(1'b0);
      chk("f_done", 32'(done), 32'(1 << (i % 4)));
      chk("f_err", 32'(err), 0);
    end

    // NACK on every attempt: three launches, then done+err
    req = 4'b0000;
    do_reset;
    req = 4'b0010;
    tick;
    chk("n_gnt", 32'(gnt), 32'h2);
    tick;
    chk("n_start_lat", 32'(m_start), 1);
    for (int a = 0; a < 3; a++) begin
      master_done(1'b1);
      if (a < 2) begin
        chk("n_no_done", 32'(done), 0);
        chk("n_gnt_kept", 32'(gnt), 32'h2);
        n = 0;
        while (m_start !== 1'b1 && n < 400) begin
          tick;
          n++;
        end
        chk("n_retry_gap", 32'(n), 9);
        chk("n_retry_addr", 32'(m_addr), 32'h11);
      end else begin
        chk("n_done", 32'(done), 32'h2);
        chk("n_err", 32'(err), 32'h2);
        chk("n_gnt_clr", 32'(gnt), 0);
      end
    end
    req = 4'b0000;
    wait_idle("n_idle");
    // ptr moved past requester 1, so requester 0 loses to nobody
    req = 4'b0011;
    tick;
    chk("n_ptr_adv", 32'(gnt), 32'h1);

    // NACK then ACK
    tick;
    chk("na_start1", 32'(m_start), 1);
    master_done(1'b1);
    chk("na_no_done", 32'(done), 0);
    wait_start("na_start2");
    master_done(1'b0);
    chk("na_done", 32'(done), 32'h1);
    chk("na_err", 32'(err), 0);
    req = 4'b0000;
    wait_idle("na_idle");

    // watchdog timeout, then the next requester is served
    req = 4'b0110;
    tick;
    chk("t_gnt", 32'(gnt), 32'h2);
    tick;
    chk("t_start", 32'(m_start), 1);
    n = 0;
    while (done === 4'b0000 && n < 400) begin
      tick;
      n++;
    end
    chk("t_latency", 32'(n), 256);
    chk("t_done", 32'(done), 32'h2);
    chk("t_err", 32'(err), 32'h2);
    req = 4'b0100;
    master_done(1'b1);
    chk("t_stray_done", 32'(done), 0);
    chk("t_stray_state", 32'(state_out), 3);
    wait_start("t_next_start");
    chk("t_next_gnt", 32'(gnt), 32'h4);
    master_done(1'b0);
    chk("t_next_done", 32'(done), 32'h4);
    chk("t_next_err", 32'(err), 0);
    req = 4'b0000;
    wait_idle("t_idle");
    req = 4'b0001;
    wait_start("t_r0_start");
    chk("t_r0_gnt", 32'(gnt), 32'h1);
    master_done(1'b0);
    chk("t_r0_done", 32'(done), 32'h1);
    req = 4'b0000;
    wait_idle("t_r0_idle");

    // reset in the middle of WAIT
    req = 4'b0010;
    wait_start("r_start");
    chk("r_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick;
    chk_zero("r_mid");
    tick;
    chk("r_no_done", 32'(done), 0);
    req = 4'b0011;
    reset = 1'b0;
    tick;
    chk("r_ptr_zero", 32'(gnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter that shares one byte-level I2C write master among `NUM_REQ` requesters. Each requester posts a 7-bit slave address and one data byte. The block grants the bus fairly and launches the master with a one-cycle start strobe. It retries NACKed transfers, enforces bus-free time between transactions, and watchdogs a hung master. It sits between client logic (config loaders, sensor pollers) and the I2C master bit engine, in the `i2c_clk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_RETRY`, 2: extra attempts after a NACK before reporting an error.
- `GAP_CYCLES`, 8: idle `i2c_clk` cycles enforced after every master completion (≥1).
- `TIMEOUT`, 255: maximum cycles in WAIT without `m_done` before abort (≥1).

- `i2c_clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high; clock `i2c_clk`
- `req`  in  NUM_REQ  request per requester; level, held until its `done` pulse
- `req_addr`  in  7*NUM_REQ  flat slave addresses; slice i = bits [7i+6:7i]
- `req_data`  in  8*NUM_REQ  flat data bytes; slice i = bits [8i+7:8i]
- `gnt`  out  NUM_REQ  one-hot grant; held from winner latch through completion
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester
- `err`  out  NUM_REQ  valid with `done`; 1 = final NACK or timeout
- `m_start`  out  1  one-cycle launch strobe to the master
- `m_addr`  out  7  latched address; stable from ISSUE until the next winner
- `m_data`  out  8  latched data; same stability as `m_addr`
- `m_busy`  in  1  master is mid-transaction
- `m_done`  in  1  one-cycle master completion pulse
- `m_nack`  in  1  valid with `m_done`; 1 = address or data not acknowledged
- `busy`  out  1  high in every state except IDLE
- `state_out`  out  3  current state encoding

## Operation
- State encodings: IDLE=0, ISSUE=1, WAIT=2, GAP=3.
- Round-robin pointer `ptr`:
  - Reset value 0.
  - Search order is ptr, ptr+1, … mod NUM_REQ.
  - After any final completion, ptr <= winner+1 mod NUM_REQ. Retries do not move ptr.
- **IDLE:**
  - If `|req`, pick the first set bit in search order.
  - Latch `m_addr`/`m_data` from that slice, set `gnt` one-hot, clear `retry_cnt`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - While `m_busy`=1, hold and keep `m_start`=0.
  - When `m_busy`=0, assert `m_start` for exactly one cycle, clear the watchdog counter, go to WAIT.
- **WAIT:**
  - **`m_done`=1 with `m_nack`=1 and `retry_cnt` < MAX_RETRY:** increment `retry_cnt`, set the retry flag, go to GAP. No `done` pulse.
  - **`m_done`=1, any other case:** pulse `done[winner]`, set `err[winner]`=`m_nack`, advance ptr, clear `gnt`, go to GAP.
  - **Watchdog reaches TIMEOUT without `m_done`:** pulse `done[winner]` with `err`=1, advance ptr, clear `gnt`, go to GAP. No retry on timeout.
- **GAP:**
  - Count GAP_CYCLES cycles.
  - Then go to ISSUE if the retry flag is set (clear the flag; `gnt` and latched data kept), else go to IDLE.
- Requester rules:
  - A requester dropping `req` after grant does not cancel its transaction; it still receives `done`.
  - `req` still high after `done` counts as a new request at the next IDLE arbitration.
- A `m_done` seen outside WAIT is ignored.
- Reset at any time:
  - State goes to IDLE; ptr=0; retry_cnt=0; watchdog=0.
  - All outputs go to 0. In-flight transaction is abandoned with no `done` pulse.
- Counter widths: `retry_cnt` holds MAX_RETRY; watchdog holds TIMEOUT; gap counter holds GAP_CYCLES. No wrap-around is reachable.

## Timing
- Reset values: `gnt`=0, `done`=0, `err`=0, `m_start`=0, `m_addr`=0, `m_data`=0, `busy`=0, `state_out`=0.
- Request to launch: `req` seen in IDLE at cycle T; `gnt` and latched data visible at T+1; `m_start` at T+2 if `m_busy`=0.
- `m_done` at cycle D: `done`/`err` high during D+1 only; GAP spans D+1..D+GAP_CYCLES.
  - First possible next IDLE decision is at cycle D+GAP_CYCLES+1.
  - A retry `m_start` occurs at D+GAP_CYCLES+2.
- Watchdog: `m_start` at cycle S with no `m_done`; `done`+`err` at S+TIMEOUT+1.
- `m_done` and timeout in the same cycle: `m_done` wins.
- `err` is 0 whenever `done` is 0.

## Test plan
- Single requester: req[2]=1, addr 7'h69, data 8'hAA, master ACKs → `gnt`=4'b0100, one `m_start` with m_addr=7'h69 and m_data=8'hAA, then done[2]=1, err[2]=0, busy low after 8 gap cycles.
- Fairness: req=4'b1111 held continuously from reset → grant order 0,1,2,3,0,…; no requester is granted twice before all others are granted once.
- NACK retry: master NACKs every attempt with MAX_RETRY=2 → exactly 3 `m_start` pulses, each separated by ≥8 idle cycles, then a single done+err; ptr advances.
- NACK then ACK: first attempt NACKed, second ACKed → 2 `m_start` pulses, done=1, err=0.
- Timeout: master never returns `m_done` → done+err exactly TIMEOUT+1 cycles after `m_start`; next requester is served afterwards.
- Reset mid-WAIT with req[1] pending → all outputs 0 the next cycle, no `done` pulse; after release, requester 0 wins if both req[0] and req[1] are asserted.
